pmu_reader: RTL and testbench
=============================

# pmu_reader

Readout side of the dTLB performance-monitor counters. Takes the three free-running 64-bit event counters (hit, miss, prefetch), captures all three atomically on a software/debug snapshot request, and streams the captured values as a fixed 7-word frame over a 32-bit valid/ready interface toward the debug/trace sink. Requests that arrive while a frame is in flight are dropped and counted.

## Interface
Parameters:
- HDR_TAG, 16'hDB1E, constant placed in header word bits [31:16]
- SEQ_W, 16, frame sequence counter width; must be ≤ 16, zero-extended into header bits [15:0]

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- snap_req  in  1  snapshot request level; a 0→1 transition requests one frame
- cnt_hit  in  64  dTLB hit counter value
- cnt_miss  in  64  dTLB miss counter value
- cnt_prefetch  in  64  dTLB prefetch counter value
- out_data  out  32  frame word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts word when out_valid && out_ready
- out_last  out  1  high with final word (index 6)
- busy  out  1  frame in flight (state SEND)
- drop_cnt  out  8  saturating count of dropped requests

## Operation
- Edge detect: register snap_prev <= snap_req every cycle; request = snap_req && !snap_prev.
- States: IDLE, SEND. busy = (state == SEND).
- IDLE + request: load snap_hit/snap_miss/snap_prefetch from inputs, idx <= 0, go SEND.
- SEND: out_valid = 1, out_data = word[idx]; on handshake idx <= idx+1; handshake at idx 6 → IDLE, seq <= seq+1 (wraps mod 2^SEQ_W).
- Frame words: 0 header {HDR_TAG, seq}; 1 hit[31:0]; 2 hit[63:32]; 3 miss[31:0]; 4 miss[63:32]; 5 prefetch[31:0]; 6 prefetch[63:32].
- Header carries seq value of the current frame (first frame after reset = 0).
- Request detected while state == SEND (including the cycle of the idx-6 handshake): ignored, drop_cnt <= drop_cnt+1, saturates at 8'hFF.
- Input counter changes after capture do not affect the frame in flight.

## Timing
- Reset (asynchronous, immediate): state IDLE, idx 0, seq 0, snap_prev 0, drop_cnt 0, snapshot regs 0; outputs out_valid 0, out_last 0, busy 0, out_data 0, drop_cnt 0.
- snap_prev resets to 0: snap_req held high across reset release produces one request at the first clock edge.
- Latency: request sampled at edge k → snapshot captured at edge k; out_valid/busy high and header on out_data in the cycle after edge k.
- Minimum frame: 7 cycles with out_ready held high; back-to-back frames need a new 0→1 edge on snap_req at or after the cycle following the last handshake (earliest restart: out_valid low for exactly one cycle).
- While out_valid && !out_ready: out_data, out_last held stable; no word skipped or repeated.
- out_valid, out_data, out_last, busy are registered outputs; no combinational path from out_ready or snap_req to any output.

## Configuration
- PMU_READER_DELTA_EN defined: words 1–6 carry snapshot minus previous snapshot per counter (64-bit, modulo 2^64); base registers reset to 0 and load the new snapshot at each capture, so the first frame after reset equals absolute values. Header unchanged.
- Undefined: words 1–6 carry absolute captured values; no base registers.

## Test plan
- Reset, cnt_hit=64'h0000_0001_0000_0002, cnt_miss=64'h5, cnt_prefetch=64'hFFFF_FFFF_FFFF_FFFF, pulse snap_req, out_ready=1 → 7 words DB1E0000, 00000002, 00000001, 00000005, 00000000, FFFFFFFF, FFFFFFFF; out_last only on word 7; busy low after.
- Same request with out_ready toggling 1-0-0-1 pattern → identical 7 words, data stable during stalls, counters changed mid-frame not reflected.
- Second request during frame, then third during frame → both dropped, drop_cnt=2; next frame header = DB1E0001.
- 300 requests while out_ready=0 held after first capture → drop_cnt saturates at 8'hFF; busy stays 1, header remains on out_data.
- rst_n low at word index 3 → out_valid/busy/out_last drop immediately; after release, new request yields header DB1E0000.
- With PMU_READER_DELTA_EN: snapshot hit=100 then hit=250 → second frame word 1 = 0x00000096 (150), word 2 = 0.

Source files
------------

// File: rtl/pmu_reader.sv
// pmu_reader: atomic snapshot of the dTLB hit/miss/prefetch counters,
// streamed out as a 7-word frame over a 32-bit valid/ready port.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   snap_req              0->1 edge requests one frame
//   cnt_hit/miss/prefetch 64-bit free-running event counters
//   out_data/valid/last   frame word stream (registered)
//   out_ready             sink accept
//   busy                  frame in flight
//   drop_cnt              saturating count of requests dropped while busy
//
// Optional feature macro: PMU_READER_DELTA_EN
//   defined   -> words 1..6 carry the difference from the previous snapshot
//   undefined -> words 1..6 carry absolute captured values
module pmu_reader #(
  parameter logic [15:0] HDR_TAG = 16'hDB1E,
  parameter int          SEQ_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snap_req,
  input  logic [63:0] cnt_hit,
  input  logic [63:0] cnt_miss,
  input  logic [63:0] cnt_prefetch,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'd6;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               snap_prev_q;
  logic [7:0]         drop_q, drop_d;
  logic [63:0]        hit_q, hit_d;
  logic [63:0]        miss_q, miss_d;
  logic [63:0]        pf_q, pf_d;
  logic [31:0]        data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

`ifdef PMU_READER_DELTA_EN
  logic [63:0]        base_hit_q, base_hit_d;
  logic [63:0]        base_miss_q, base_miss_d;
  logic [63:0]        base_pf_q, base_pf_d;
`endif

  logic               req;
  logic               hs;

  function automatic logic [31:0] word_f(
    input logic [2:0]  i,
    input logic [15:0] hseq,
    input logic [63:0] h,
    input logic [63:0] m,
    input logic [63:0] p
  );
    logic [31:0] w;
    case (i)
      3'd0:    w = {HDR_TAG, hseq};
      3'd1:    w = h[31:0];
      3'd2:    w = h[63:32];
      3'd3:    w = m[31:0];
      3'd4:    w = m[63:32];
      3'd5:    w = p[31:0];
      3'd6:    w = p[63:32];
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  assign req = snap_req && !snap_prev_q;
  assign hs  = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    pf_d    = pf_q;
`ifdef PMU_READER_DELTA_EN
    base_hit_d  = base_hit_q;
    base_miss_d = base_miss_q;
    base_pf_d   = base_pf_q;
`endif

    case (state_q)
      IDLE: begin
        if (req) begin
`ifdef PMU_READER_DELTA_EN
          // Snapshot regs hold the per-counter delta; bases track
          // the raw value of the last capture.
          hit_d       = cnt_hit - base_hit_q;
          miss_d      = cnt_miss - base_miss_q;
          pf_d        = cnt_prefetch - base_pf_q;
          base_hit_d  = cnt_hit;
          base_miss_d = cnt_miss;
          base_pf_d   = cnt_prefetch;
`else
          hit_d  = cnt_hit;
          miss_d = cnt_miss;
          pf_d   = cnt_prefetch;
`endif
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (req && drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 3'd0;
            seq_d   = seq_q + SEQ_W'(1);
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next state so they can be registered.
    valid_d = (state_d == SEND);
    last_d  = (state_d == SEND) && (idx_d == LAST_IDX);
    data_d  = 32'h0;
    if (state_d == SEND) begin
      data_d = word_f(idx_d, 16'(seq_d), hit_d, miss_d, pf_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      seq_q       <= '0;
      snap_prev_q <= 1'b0;
      drop_q      <= 8'h0;
      hit_q       <= 64'h0;
      miss_q      <= 64'h0;
      pf_q        <= 64'h0;
      data_q      <= 32'h0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      snap_prev_q <= snap_req;
      drop_q      <= drop_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      pf_q        <= pf_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

`ifdef PMU_READER_DELTA_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_hit_q  <= 64'h0;
      base_miss_q <= 64'h0;
      base_pf_q   <= 64'h0;
    end else begin
      base_hit_q  <= base_hit_d;
      base_miss_q <= base_miss_d;
      base_pf_q   <= base_pf_d;
    end
  end
`endif

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = (state_q == SEND);
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pmu_reader.sv
// tb_pmu_reader: directed self-checking bench for pmu_reader.
// Builds with or without PMU_READER_DELTA_EN.
`timescale 1ns/1ps
module tb_pmu_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snap_req = 1'b0;
  logic [63:0] cnt_hit = 64'h0;
  logic [63:0] cnt_miss = 64'h0;
  logic [63:0] cnt_prefetch = 64'h0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic [7:0]  drop_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] rw [0:6];
  logic [6:0]  lastmask;
  int          got;
  int          stall_err;

  logic [31:0] exp1 [0:6];

  pmu_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .snap_req     (snap_req),
    .cnt_hit      (cnt_hit),
    .cnt_miss     (cnt_miss),
    .cnt_prefetch (cnt_prefetch),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    snap_req = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_cnts();
    cnt_hit      = 64'h0000_0001_0000_0002;
    cnt_miss     = 64'h5;
    cnt_prefetch = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic pulse();
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
  endtask

  // Called at a negedge with a frame in flight; returns at the negedge
  // where word 6 is presented with out_ready high.
  task automatic recv(input int mode);
    logic        ps;
    logic [31:0] pd;
    logic        pl;
    got = 0;
    lastmask = '0;
    stall_err = 0;
    ps = 1'b0;
    pd = '0;
    pl = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (mode == 0) out_ready = 1'b1;
      else out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (ps && (out_data !== pd || out_last !== pl)) stall_err++;
      if (out_valid && out_ready) begin
        rw[got] = out_data;
        lastmask[got] = out_last;
        got++;
        if (got == 7) break;
      end
      ps = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
        out_data !== 32'h0 || drop_cnt !== 8'h0) begin
      fails++;
      $display("FAIL reset_state: v=%b l=%b b=%b d=%h dc=%h want all 0",
               out_valid, out_last, busy, out_data, drop_cnt);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    set_cnts();
    pulse();
    recv(0);
    tests++;
    if (got != 7) begin
      fails++;
      $display("FAIL basic_count: got %0d words want 7", got);
    end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (rw[i] !== exp1[i]) begin
        fails++;
        $display("FAIL basic_word%0d: got %h want %h", i, rw[i], exp1[i]);
      end
    end
    tests++;
    if (lastmask !== 7'b1000000) begin
      fails++;
      $display("FAIL basic_last: got %b want 1000000", lastmask);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle: busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_cnts();
    pulse();
    cnt_hit      = 64'h1111_2222_3333_4444;
    cnt_miss     = 64'h5555_6666_7777_8888;
    cnt_prefetch = 64'h0;
    recv(1);
    tests++;
    if (got != 7 || stall_err != 0) begin
      fails++;
      $display("FAIL stall_flow: got %0d words, %0d unstable want 7, 0",
               got, stall_err);
    end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (rw[i] !== exp1[i]) begin
        fails++;
        $display("FAIL stall_word%0d: got %h want %h", i, rw[i], exp1[i]);
      end
    end
    tests++;
    if (lastmask !== 7'b1000000) begin
      fails++;
      $display("FAIL stall_last: got %b want 1000000", lastmask);
    end
    set_cnts();
    @(negedge clk);
  endtask

  task automatic test_drop();
    do_reset();
    pulse();
    @(negedge clk);
    pulse();
    @(negedge clk);
    pulse();
    @(negedge clk);
    tests++;
    if (drop_cnt !== 8'd2 || busy !== 1'b1 || out_data !== 32'hDB1E0000) begin
      fails++;
      $display("FAIL drop_two: dc=%h busy=%b d=%h want 02 1 db1e0000",
               drop_cnt, busy, out_data);
    end
    recv(0);
    @(negedge clk);
    pulse();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hDB1E0001) begin
      fails++;
      $display("FAIL drop_next_hdr: v=%b d=%h want 1 db1e0001",
               out_valid, out_data);
    end
    recv(0);
    @(negedge clk);
  endtask

  task automatic test_saturate();
    do_reset();
    pulse();
    repeat (300) begin
      pulse();
      @(negedge clk);
    end
    tests++;
    if (drop_cnt !== 8'hFF) begin
      fails++;
      $display("FAIL sat_cnt: got %h want ff", drop_cnt);
    end
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hDB1E0000) begin
      fails++;
      $display("FAIL sat_hold: busy=%b v=%b d=%h want 1 1 db1e0000",
               busy, out_valid, out_data);
    end
    recv(0);
    tests++;
    if (got != 7) begin
      fails++;
      $display("FAIL sat_drain: got %0d words want 7", got);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    pulse();
    repeat (3) @(negedge clk);
    tests++;
    if (out_data !== 32'h00000005) begin
      fails++;
      $display("FAIL mid_word3: got %h want 00000005", out_data);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: v=%b b=%b l=%b want 0 0 0",
               out_valid, busy, out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hDB1E0000) begin
      fails++;
      $display("FAIL mid_restart: v=%b d=%h want 1 db1e0000",
               out_valid, out_data);
    end
    recv(0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse();
    recv(0);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap: valid=%b want 0", out_valid);
    end
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hDB1E0001) begin
      fails++;
      $display("FAIL b2b_hdr: v=%b d=%h want 1 db1e0001", out_valid, out_data);
    end
    recv(0);
    tests++;
    if (got != 7 || rw[1] !== 32'h00000002) begin
      fails++;
      $display("FAIL b2b_frame: got %0d w1=%h want 7 00000002", got, rw[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_held_through_reset();
    rst_n = 1'b0;
    snap_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'hDB1E0000) begin
      fails++;
      $display("FAIL held_req: v=%b d=%h want 1 db1e0000", out_valid, out_data);
    end
    recv(0);
    @(negedge clk);
  endtask

  task automatic test_delta();
    do_reset();
    cnt_hit = 64'd100;
    pulse();
    recv(0);
    tests++;
    if (rw[1] !== 32'd100 || rw[2] !== 32'd0) begin
      fails++;
      $display("FAIL delta_first: w1=%h w2=%h want 00000064 0", rw[1], rw[2]);
    end
    @(negedge clk);
    cnt_hit = 64'd250;
    pulse();
    recv(0);
`ifdef PMU_READER_DELTA_EN
    tests++;
    if (rw[1] !== 32'h00000096 || rw[2] !== 32'h0) begin
      fails++;
      $display("FAIL delta_second: w1=%h w2=%h want 00000096 0", rw[1], rw[2]);
    end
`else
    tests++;
    if (rw[1] !== 32'h000000FA || rw[2] !== 32'h0) begin
      fails++;
      $display("FAIL abs_second: w1=%h w2=%h want 000000fa 0", rw[1], rw[2]);
    end
`endif
    @(negedge clk);
    set_cnts();
  endtask

  initial begin
    exp1[0] = 32'hDB1E0000;
    exp1[1] = 32'h00000002;
    exp1[2] = 32'h00000001;
    exp1[3] = 32'h00000005;
    exp1[4] = 32'h00000000;
    exp1[5] = 32'hFFFFFFFF;
    exp1[6] = 32'hFFFFFFFF;
    set_cnts();
    test_reset();
    test_basic();
    test_stall();
    test_drop();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    test_held_through_reset();
    test_delta();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
